// File: rtl/uart_bus_arbiter_if.sv
// rtl/uart_bus_arbiter_if.sv - master/UART bus bundle for the two-master UART arbiter
//
// Purpose: groups the two master request/handshake channels and the UART-side
// transfer signals into one bundle.
//   slave  modport : the arbiter (consumes requests, drives grants and UART side)
//   master modport : the environment (drives requests and UART acks/errors)
// Signals:
//   mN_req/rw/addr/word_number/wvalid/wdata : master N burst request and write word
//   mN_grant/wack/done/error                : master N ownership and status pulses
//   uart_as/rw/write_ready/write_data/addr/word_number : transfer toward the UART
//   uart_word_ack/uart_bus_error            : UART word consumed / bus error flag
interface uart_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 33,
  parameter int WN_W   = 4
);
  logic              m0_req;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [WN_W-1:0]   m0_word_number;
  logic              m0_wvalid;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_grant;
  logic              m0_wack;
  logic              m0_done;
  logic              m0_error;

  logic              m1_req;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [WN_W-1:0]   m1_word_number;
  logic              m1_wvalid;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_grant;
  logic              m1_wack;
  logic              m1_done;
  logic              m1_error;

  logic              uart_as;
  logic              uart_rw;
  logic              uart_write_ready;
  logic [DATA_W-1:0] uart_write_data;
  logic [ADDR_W-1:0] uart_addr;
  logic [WN_W-1:0]   uart_word_number;
  logic              uart_word_ack;
  logic              uart_bus_error;

  modport slave (
    input  m0_req, m0_rw, m0_addr, m0_word_number, m0_wvalid, m0_wdata,
    input  m1_req, m1_rw, m1_addr, m1_word_number, m1_wvalid, m1_wdata,
    output m0_grant, m0_wack, m0_done, m0_error,
    output m1_grant, m1_wack, m1_done, m1_error,
    output uart_as, uart_rw, uart_write_ready, uart_write_data, uart_addr, uart_word_number,
    input  uart_word_ack, uart_bus_error
  );

  modport master (
    output m0_req, m0_rw, m0_addr, m0_word_number, m0_wvalid, m0_wdata,
    output m1_req, m1_rw, m1_addr, m1_word_number, m1_wvalid, m1_wdata,
    input  m0_grant, m0_wack, m0_done, m0_error,
    input  m1_grant, m1_wack, m1_done, m1_error,
    input  uart_as, uart_rw, uart_write_ready, uart_write_data, uart_addr, uart_word_number,
    output uart_word_ack, uart_bus_error
  );
endinterface

// File: rtl/uart_bus_arbiter.sv
// rtl/uart_bus_arbiter.sv - round-robin arbiter giving two masters burst access to one UART
//
// Purpose: grants one of two masters the UART for a burst of word_number words,
// forwards its write words, counts UART word acks and reports done/error.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : uart_bus_arbiter_if.slave (master channels + UART side)
// uart_rw encoding: 0 = write, 1 = read.
module uart_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 33,
  parameter int WN_W   = 4
) (
  input logic               clk,
  input logic               reset,
  uart_bus_arbiter_if.slave bus
);

  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, DONE, ERR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_gnt;      // index of the master owning the current burst
  logic              r_last;     // master granted most recently
  logic [WN_W-1:0]   r_cnt;      // words still to be acked
  logic              r_as;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [WN_W-1:0]   r_wn;
  logic [1:0]        r_grant;

  logic              w_pick;
  logic              w_next_gnt;
  logic              w_req_g;
  logic              w_wvalid_g;
  logic [DATA_W-1:0] w_wdata_g;
  logic              w_wack;
  logic              w_grant_edge;
  logic              w_load_cnt;

  // Arbitration: a lone request wins outright; with both pending the master
  // that was not granted last time wins.
  always_comb begin
    w_pick = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      w_pick = ~r_last;
    end else if (bus.m1_req) begin
      w_pick = 1'b1;
    end
  end

  assign w_req_g    = r_gnt ? bus.m1_req    : bus.m0_req;
  assign w_wvalid_g = r_gnt ? bus.m1_wvalid : bus.m0_wvalid;
  assign w_wdata_g  = r_gnt ? bus.m1_wdata  : bus.m0_wdata;

  // Next-state logic. Within a burst: dropped request > bus error > ack.
  always_comb begin
    w_next = r_state;
    w_wack = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) w_next = SETUP;
      end
      SETUP: begin
        if (!w_req_g)                w_next = IDLE;
        else if (bus.uart_bus_error) w_next = ERR;
        else if (r_wn == '0)         w_next = DONE;
        else                         w_next = XFER;
      end
      XFER: begin
        if (!w_req_g) begin
          w_next = IDLE;
        end else if (bus.uart_bus_error) begin
          w_next = ERR;
        end else if (bus.uart_word_ack) begin
          w_wack = 1'b1;
          if (r_cnt == WN_W'(1)) w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_grant_edge = (r_state == IDLE) && (w_next == SETUP);
  assign w_load_cnt   = (r_state == SETUP) && (w_next == XFER);
  assign w_next_gnt   = (r_state == IDLE) ? w_pick : r_gnt;

  // Burst datapath and registered outputs, all computed from the next state
  // so that grant and uart_as change exactly on the state transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_as    <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wn    <= '0;
      r_grant <= 2'b00;
    end else begin
      if (w_grant_edge) begin
        r_gnt  <= w_pick;
        r_last <= w_pick;
        r_rw   <= w_pick ? bus.m1_rw          : bus.m0_rw;
        r_addr <= w_pick ? bus.m1_addr        : bus.m0_addr;
        r_wn   <= w_pick ? bus.m1_word_number : bus.m0_word_number;
      end
      if (w_load_cnt) begin
        r_cnt <= r_wn;
      end else if (w_wack) begin
        r_cnt <= r_cnt - WN_W'(1);
      end
      r_as       <= (w_next == SETUP) || (w_next == XFER);
      r_grant[0] <= (w_next != IDLE) && !w_next_gnt;
      r_grant[1] <= (w_next != IDLE) &&  w_next_gnt;
    end
  end

  assign bus.m0_grant = r_grant[0];
  assign bus.m1_grant = r_grant[1];
  assign bus.m0_wack  = w_wack && !r_gnt;
  assign bus.m1_wack  = w_wack &&  r_gnt;
  assign bus.m0_done  = (r_state == DONE) && !r_gnt;
  assign bus.m1_done  = (r_state == DONE) &&  r_gnt;
  assign bus.m0_error = (r_state == ERR)  && !r_gnt;
  assign bus.m1_error = (r_state == ERR)  &&  r_gnt;

  assign bus.uart_as          = r_as;
  assign bus.uart_rw          = r_rw;
  assign bus.uart_addr        = r_addr;
  assign bus.uart_word_number = r_wn;
  assign bus.uart_write_ready = (r_state == XFER) && (r_rw == RW_WRITE) && w_wvalid_g;
  assign bus.uart_write_data  = (r_state == XFER) ? w_wdata_g : '0;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb/tb_uart_bus_arbiter.sv - scoreboard bench for uart_bus_arbiter
module tb_uart_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 33;
  localparam int WN_W   = 4;

  localparam int EV_GRANT = 0;
  localparam int EV_WACK  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  localparam int M_NORMAL = 0;
  localparam int M_ERR    = 1;
  localparam int M_ABORT  = 2;

  typedef struct {
    int                kind;
    int                m;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [WN_W-1:0]   wn;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  uart_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WN_W(WN_W)) bus ();

  uart_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WN_W(WN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  ev_t sb[$];

  // Reference model state: which master owns the bus and which phase it is in.
  int  last_m = 1;
  int  cur_m  = 0;
  bit  cur_rw = 1'b0;
  bit  g_f    = 1'b0;
  bit  as_f   = 1'b0;
  bit  xfer_f = 1'b0;

  logic prev_g0 = 1'b0;
  logic prev_g1 = 1'b0;
  logic [DATA_W-1:0] exp_data;
  logic              exp_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int kind, input int m, input logic [ADDR_W-1:0] addr,
                                  input logic rw, input logic [WN_W-1:0] wn);
    ev_t e;
    e.kind = kind; e.m = m; e.addr = addr; e.rw = rw; e.wn = wn;
    sb.push_back(e);
  endfunction

  task automatic ev_check(input int kind, input int m);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind=%0d master=%0d, required no event (t=%0t)", kind, m, $time);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_master", 64'(m), 64'(e.m));
      if (kind == EV_GRANT && e.kind == EV_GRANT) begin
        chk("grant_uart_addr", 64'(bus.uart_addr), 64'(e.addr));
        chk("grant_uart_rw", 64'(bus.uart_rw), 64'(e.rw));
        chk("grant_uart_wn", 64'(bus.uart_word_number), 64'(e.wn));
      end
    end
  endtask

  // Monitor: per-cycle level checks plus scoreboard pops on every event.
  always @(negedge clk) begin
    exp_data  = '0;
    exp_ready = 1'b0;
    if (xfer_f) begin
      exp_data  = (cur_m == 0) ? bus.m0_wdata : bus.m1_wdata;
      exp_ready = (cur_rw == 1'b0) && ((cur_m == 0) ? bus.m0_wvalid : bus.m1_wvalid);
    end
    chk("m0_grant", 64'(bus.m0_grant), 64'(g_f && cur_m == 0));
    chk("m1_grant", 64'(bus.m1_grant), 64'(g_f && cur_m == 1));
    chk("uart_as", 64'(bus.uart_as), 64'(as_f));
    chk("uart_write_ready", 64'(bus.uart_write_ready), 64'(exp_ready));
    chk("uart_write_data", 64'(bus.uart_write_data), 64'(exp_data));
    if (bus.m0_grant && !prev_g0) ev_check(EV_GRANT, 0);
    if (bus.m1_grant && !prev_g1) ev_check(EV_GRANT, 1);
    if (bus.m0_wack)  ev_check(EV_WACK, 0);
    if (bus.m1_wack)  ev_check(EV_WACK, 1);
    if (bus.m0_done)  ev_check(EV_DONE, 0);
    if (bus.m1_done)  ev_check(EV_DONE, 1);
    if (bus.m0_error) ev_check(EV_ERR, 0);
    if (bus.m1_error) ev_check(EV_ERR, 1);
    prev_g0 <= bus.m0_grant;
    prev_g1 <= bus.m1_grant;
  end

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m0_rw = 1'b0; bus.m0_addr = '0; bus.m0_word_number = '0;
    bus.m0_wvalid = 1'b0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_rw = 1'b0; bus.m1_addr = '0; bus.m1_word_number = '0;
    bus.m1_wvalid = 1'b0; bus.m1_wdata = '0;
    bus.uart_word_ack = 1'b0; bus.uart_bus_error = 1'b0;
  endtask

  task automatic set_master(input int m, input logic rw, input logic [ADDR_W-1:0] addr,
                            input logic [WN_W-1:0] wn);
    if (m == 0) begin
      bus.m0_req = 1'b1; bus.m0_rw = rw; bus.m0_addr = addr; bus.m0_word_number = wn;
    end else begin
      bus.m1_req = 1'b1; bus.m1_rw = rw; bus.m1_addr = addr; bus.m1_word_number = wn;
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  task automatic rand_wr(input int m, input bit hold_valid);
    logic [63:0] t0;
    logic [63:0] t1;
    t0 = {$urandom, $urandom};
    t1 = {$urandom, $urandom};
    bus.m0_wdata  = t0[DATA_W-1:0];
    bus.m1_wdata  = t1[DATA_W-1:0];
    bus.m0_wvalid = 1'($urandom_range(1));
    bus.m1_wvalid = 1'($urandom_range(1));
    if (hold_valid) begin
      if (m == 0) bus.m0_wvalid = 1'b1;
      else        bus.m1_wvalid = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grants"}, 64'({bus.m0_grant, bus.m1_grant}), 64'(0));
    chk({tag, "_pulses"}, 64'({bus.m0_wack, bus.m0_done, bus.m0_error,
                               bus.m1_wack, bus.m1_done, bus.m1_error}), 64'(0));
    chk({tag, "_uart_ctl"}, 64'({bus.uart_as, bus.uart_rw, bus.uart_write_ready}), 64'(0));
    chk({tag, "_uart_addr"}, 64'(bus.uart_addr), 64'(0));
    chk({tag, "_uart_wn"}, 64'(bus.uart_word_number), 64'(0));
    chk({tag, "_uart_wdata"}, 64'(bus.uart_write_data), 64'(0));
  endtask

  // Runs one burst for master m starting in an IDLE cycle. mode/k choose the
  // outcome: normal, bus error on the k-th ack attempt (k=0: during setup),
  // or request dropped after k accepted words.
  task automatic run_burst(input int m, input logic rw, input logic [ADDR_W-1:0] addr,
                           input logic [WN_W-1:0] wn, input int mode, input int k,
                           input bit full_ack);
    int fin;
    int acks;
    set_master(m, rw, addr, wn);
    push_ev(EV_GRANT, m, addr, rw, wn);
    last_m = m;
    @(posedge clk); #1;
    cur_m = m; cur_rw = rw; g_f = 1'b1; as_f = 1'b1; xfer_f = 1'b0;
    rand_wr(m, full_ack);
    bus.uart_word_ack = 1'($urandom_range(1));
    fin  = 0;
    acks = 0;
    if (mode == M_ERR && k == 0) begin
      bus.uart_bus_error = 1'b1;
      push_ev(EV_ERR, m, '0, 1'b0, '0);
      fin = 2;
    end else if (mode == M_ABORT && k == 0) begin
      drop_req(m);
      fin = 3;
    end else if (wn == '0) begin
      push_ev(EV_DONE, m, '0, 1'b0, '0);
      fin = 1;
    end
    while (fin == 0) begin
      @(posedge clk); #1;
      xfer_f = 1'b1;
      rand_wr(m, full_ack);
      bus.uart_word_ack  = 1'b0;
      bus.uart_bus_error = 1'b0;
      if (mode == M_ABORT && acks == k) begin
        drop_req(m);
        fin = 3;
      end else if (full_ack || $urandom_range(3) != 0) begin
        bus.uart_word_ack = 1'b1;
        if (mode == M_ERR && acks + 1 == k) begin
          bus.uart_bus_error = 1'b1;
          push_ev(EV_ERR, m, '0, 1'b0, '0);
          fin = 2;
        end else begin
          push_ev(EV_WACK, m, '0, 1'b0, '0);
          acks++;
          if (acks == int'(wn)) begin
            push_ev(EV_DONE, m, '0, 1'b0, '0);
            fin = 1;
          end
        end
      end
    end
    @(posedge clk); #1;
    bus.uart_word_ack  = 1'b0;
    bus.uart_bus_error = 1'b0;
    as_f   = 1'b0;
    xfer_f = 1'b0;
    if (fin == 3) begin
      g_f = 1'b0;
    end else begin
      drop_req(m);
      @(posedge clk); #1;
      g_f = 1'b0;
    end
  endtask

  task automatic random_burst(input int m, input bit full_ack);
    logic [WN_W-1:0] wn;
    int mode;
    int k;
    wn   = WN_W'($urandom_range(0, 6));
    mode = $urandom_range(0, 2);
    k    = 0;
    if (mode == M_ERR)   k = $urandom_range(0, int'(wn));
    if (mode == M_ABORT) k = (wn == '0) ? 0 : $urandom_range(0, int'(wn) - 1);
    run_burst(m, 1'($urandom_range(1)), $urandom, wn, mode, k, full_ack);
  endtask

  // With both masters requesting, the model picks the one not granted last;
  // the loser keeps requesting and is served right after.
  task automatic burst_pair(input bit both, input bit full_ack);
    int w;
    if (both) begin
      w = (last_m == 1) ? 0 : 1;
      set_master(1 - w, 1'($urandom_range(1)), $urandom, WN_W'($urandom_range(0, 6)));
      random_burst(w, full_ack);
      random_burst(1 - w, full_ack);
    end else begin
      random_burst($urandom_range(1), full_ack);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.m0_addr = 32'hDEAD_BEEF;
    bus.m0_word_number = 4'd5; bus.uart_word_ack = 1'b1; bus.m0_wvalid = 1'b1;
    bus.m0_wdata = 33'h1_2345_6789;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    clear_inputs();
    reset = 1'b0;
    @(posedge clk); #1;

    // Contention after reset: m0 first, then m1; again both -> m0.
    burst_pair(1'b1, 1'b1);
    burst_pair(1'b1, 1'b0);

    // Single write, 4 words, ack every cycle.
    run_burst(0, 1'b0, 32'h0000_0001, 4'd4, M_NORMAL, 0, 1'b1);
    // m1, 3 words, error on the second ack cycle.
    run_burst(1, 1'b0, 32'h0000_0100, 4'd3, M_ERR, 2, 1'b1);
    // Zero-length burst.
    run_burst(0, 1'b0, 32'h0000_0020, 4'd0, M_NORMAL, 0, 1'b1);
    // Request dropped after 1 of 4 acks.
    run_burst(0, 1'b0, 32'h0000_0040, 4'd4, M_ABORT, 1, 1'b1);
    // Read burst and full-length error/zero corner cases.
    run_burst(1, 1'b1, 32'h0000_0080, 4'd15, M_NORMAL, 0, 1'b0);
    run_burst(0, 1'b0, 32'h0000_00C0, 4'd2, M_ERR, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      burst_pair(1'($urandom_range(1)), 1'b0);
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
        end
      end
    end

    // Reset in the middle of a transfer.
    set_master(0, 1'b0, 32'h0000_0ABC, 4'd4);
    push_ev(EV_GRANT, 0, 32'h0000_0ABC, 1'b0, 4'd4);
    last_m = 0;
    @(posedge clk); #1;
    cur_m = 0; cur_rw = 1'b0; g_f = 1'b1; as_f = 1'b1;
    rand_wr(0, 1'b1);
    @(posedge clk); #1;
    xfer_f = 1'b1;
    bus.uart_word_ack = 1'b1;
    push_ev(EV_WACK, 0, '0, 1'b0, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    g_f = 1'b0; as_f = 1'b0; xfer_f = 1'b0;
    last_m = 1;
    bus.m1_req = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    check_all_zero("midreset_held");
    bus.uart_word_ack = 1'b0;
    reset = 1'b0;
    burst_pair(1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_arbiter.md
UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the bus address width.
REQ-002 The block SHALL have parameter DATA_W, default 33, giving the bus data width.
REQ-003 The block SHALL have parameter WN_W, default 4, giving the word-count width.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
 clk  in  1  sole clock, rising edge.
 reset  in  1  asynchronous, active-high reset.
 mN_req  in  1  master N (N=0,1) requests the UART; held for the whole burst.
 mN_rw  in  1  master N read/write select.
 mN_addr  in  ADDR_W  master N start address.
 mN_word_number  in  WN_W  master N burst length in words.
 mN_wvalid  in  1  master N write word is valid.
 mN_wdata  in  DATA_W  master N write word.
 mN_grant  out  1  master N owns the UART.
 mN_wack  out  1  one-cycle pulse: master N's current word was accepted.
 mN_done  out  1  one-cycle pulse: master N's burst completed.
 mN_error  out  1  one-cycle pulse: master N's burst aborted by a bus error.
 uart_as  out  1  UART address strobe/select.
 uart_rw  out  1  UART read/write select.
 uart_write_ready  out  1  write word present toward the UART.
 uart_write_data  out  DATA_W  write word toward the UART.
 uart_addr  out  ADDR_W  UART transfer address.
 uart_word_number  out  WN_W  UART burst length.
 uart_word_ack  in  1  the UART consumed one word this cycle.
 uart_bus_error  in  1  the UART parity/bus error flag.

Function
REQ-005 The FSM SHALL have states IDLE, SETUP, XFER, DONE, ERR; transitions occur on the rising edge of clk only.
REQ-006 In IDLE with exactly one mN_req high, the FSM SHALL grant master N and go to SETUP.
REQ-007 In IDLE with both requests high, the FSM SHALL grant the master not granted most recently (round-robin); the last-grant register SHALL be 1 after reset, so m0 wins first.
REQ-008 On entering SETUP, the block SHALL register mN_rw, mN_addr, and mN_word_number into uart_rw, uart_addr, and uart_word_number, and SHALL assert uart_as.
REQ-009 In SETUP, a word count of 0 SHALL go to DONE without asserting uart_write_ready; otherwise the FSM SHALL load the remaining-word counter and go to XFER.
REQ-010 In XFER, uart_write_ready SHALL equal mN_wvalid of the granted master when uart_rw is write, and 0 when uart_rw is read.
REQ-011 In XFER, uart_write_data SHALL be mN_wdata of the granted master; in all other states it SHALL be 0.
REQ-012 Each cycle in XFER with uart_word_ack high SHALL pulse mN_wack and decrement the counter.
REQ-013 An ack while the counter equals 1 SHALL go to DONE.
REQ-014 DONE SHALL pulse mN_done for one cycle, deassert uart_as and the grant, then return to IDLE.
REQ-015 uart_bus_error high in SETUP or XFER SHALL go to ERR, taking priority over a same-cycle ack; the count SHALL NOT decrement and mN_wack SHALL NOT pulse.
REQ-016 ERR SHALL pulse mN_error for one cycle, deassert uart_as and the grant, then return to IDLE.
REQ-017 mN_req falling in SETUP or XFER SHALL abort to IDLE on the next edge, with no done or error pulse and uart_as deasserted.
REQ-018 The last-grant register SHALL update on every grant; a new grant SHALL NOT be issued in the same cycle as DONE or ERR (minimum one IDLE cycle between bursts).
REQ-019 mN_grant SHALL be a registered output: high exactly from SETUP through DONE/ERR for the granted master, and never high for both masters.
REQ-020 Requests from the non-granted master SHALL be ignored until IDLE.

Reset
REQ-021 Asserting reset SHALL asynchronously force the FSM to IDLE, the counter to 0, and the last-grant register to 1.
REQ-022 While reset is asserted, all outputs SHALL be 0, including uart_addr, uart_word_number, and uart_write_data.
REQ-023 Reset asserted mid-burst SHALL abandon the burst with no done or error pulse.

Verification
REQ-024 Single write: m0 req, rw=write, addr 0x00000001, word_number 4, wvalid held, uart_word_ack every cycle -> m0_grant; uart_as with addr 0x1; 4 m0_wack pulses; m0_done one cycle after the 4th ack; grant drops.
REQ-025 Contention: m0 and m1 request in the same cycle after reset -> m0 served first; after m0_done and one IDLE cycle, m1 is granted; repeating both requests then grants m0 again.
REQ-026 Error: m1 burst of 3 words with uart_bus_error on the 2nd ack cycle -> exactly 1 m1_wack, one m1_error pulse, no m1_done, then IDLE.
REQ-027 Zero length: m0 word_number 0 -> SETUP, then DONE; uart_write_ready never high; one m0_done pulse.
REQ-028 Abort and reset: m0 drops req after 1 of 4 acks -> IDLE with no done or error; separately, reset asserted mid-XFER -> all outputs 0 immediately, and m0 wins arbitration next.
